flatten_stage: RTL and testbench

FLATTEN_STAGE -- requirements
Module: flatten_stage

---
 rtl/flatten_stage.sv | 149 ++++++++++++++
 tb/tb_flatten_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flatten_stage.sv
// Flatten stage: copies a max-pooled bank into the flattened bank,
// one read and one write per word, tracking the largest word seen.
module flatten_stage #(
  parameter logic [2:0] SRC_SEL = 3'b011,
  parameter logic [2:0] DST_SEL = 3'b101,
  parameter int         N_WORDS = 1024,
  parameter logic       CH      = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        crd,
  output logic [11:0] caddr_rd,
  input  logic [19:0] cdata_rd,
  output logic        cwr,
  output logic [11:0] caddr_wr,
  output logic [19:0] cdata_wr,
  output logic [2:0]  csel,
  output logic [19:0] max_val,
  output logic [9:0]  max_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [9:0] LAST = 10'(N_WORDS - 1);

  state_t      state;
  state_t      state_nx;
  logic [9:0]  idx;
  logic [19:0] data_q;
  logic [19:0] run_max;
  logic [9:0]  run_idx;
  logic [11:0] rd_addr_q;
  logic [11:0] wr_addr_q;
  logic        last;
  logic        accept;

  assign last   = (idx == LAST);
  assign accept = (state == S_IDLE) && start;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state: fixed RD/CAP/WR cadence per word
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_RD;
      S_RD:    state_nx = S_CAP;
      S_CAP:   state_nx = S_WR;
      S_WR:    state_nx = last ? S_DONE : S_RD;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Word index: cleared on accept, advanced after each write
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          idx <= '0;
    else if (accept)                    idx <= '0;
    else if (state == S_WR && !last)    idx <= idx + 10'd1;
  end

  // Capture read data at the end of CAP
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 data_q <= '0;
    else if (state == S_CAP)   data_q <= cdata_rd;
  end

  // Running max; strict compare so ties keep the earlier index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_max <= '0;
      run_idx <= '0;
    end else if (accept) begin
      run_max <= '0;
      run_idx <= '0;
    end else if (state == S_CAP && cdata_rd > run_max) begin
      run_max <= cdata_rd;
      run_idx <= idx;
    end
  end

  // Publish the run result on entering DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_val <= '0;
      max_idx <= '0;
    end else if (state == S_WR && last) begin
      max_val <= run_max;
      max_idx <= run_idx;
    end
  end

  // Remember addresses so they hold outside their strobe states
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr_q <= '0;
      wr_addr_q <= '0;
    end else begin
      if (state == S_RD) rd_addr_q <= {2'b00, idx};
      if (state == S_WR) wr_addr_q <= {1'b0, idx, CH};
    end
  end

  // Outputs decoded from state and registers only
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    crd      = 1'b0;
    cwr      = 1'b0;
    csel     = 3'b000;
    caddr_rd = rd_addr_q;
    caddr_wr = wr_addr_q;
    cdata_wr = data_q;
    unique case (state)
      S_RD: begin
        busy     = 1'b1;
        crd      = 1'b1;
        csel     = SRC_SEL;
        caddr_rd = {2'b00, idx};
      end
      S_CAP: begin
        busy = 1'b1;
        csel = SRC_SEL;
      end
      S_WR: begin
        busy     = 1'b1;
        cwr      = 1'b1;
        csel     = DST_SEL;
        caddr_wr = {1'b0, idx, CH};
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_flatten_stage.sv
// Bench for flatten_stage: table-driven runs, random runs against a
// reference model, abort-by-reset and back-to-back start sequences.
module tb_flatten_stage;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  logic        busy_a, done_a, crd_a, cwr_a;
  logic [11:0] caddr_rd_a, caddr_wr_a;
  logic [19:0] cdata_rd_a, cdata_wr_a, max_val_a;
  logic [2:0]  csel_a;
  logic [9:0]  max_idx_a;

  logic        busy_b, done_b, crd_b, cwr_b;
  logic [11:0] caddr_rd_b, caddr_wr_b;
  logic [19:0] cdata_rd_b, cdata_wr_b, max_val_b;
  logic [2:0]  csel_b;
  logic [9:0]  max_idx_b;

  logic [19:0] src   [1024];
  logic [19:0] dst_a [2048];
  logic [19:0] dst_b [2048];
  int wcnt_a = 0;
  int wcnt_b = 0;
  int viol = 0;
  int done_cnt_a = 0;
  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  flatten_stage dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .busy(busy_a), .done(done_a),
    .crd(crd_a), .caddr_rd(caddr_rd_a), .cdata_rd(cdata_rd_a),
    .cwr(cwr_a), .caddr_wr(caddr_wr_a), .cdata_wr(cdata_wr_a),
    .csel(csel_a), .max_val(max_val_a), .max_idx(max_idx_a)
  );

  flatten_stage #(.CH(1'b1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .busy(busy_b), .done(done_b),
    .crd(crd_b), .caddr_rd(caddr_rd_b), .cdata_rd(cdata_rd_b),
    .cwr(cwr_b), .caddr_wr(caddr_wr_b), .cdata_wr(cdata_wr_b),
    .csel(csel_b), .max_val(max_val_b), .max_idx(max_idx_b)
  );

  // Memory model: read data valid the cycle after crd, junk otherwise
  always @(posedge clk) begin
    cdata_rd_a <= crd_a ? src[caddr_rd_a[9:0]] : 20'hABCDE;
    cdata_rd_b <= crd_b ? src[caddr_rd_b[9:0]] : 20'hABCDE;
    if (cwr_a) begin
      dst_a[caddr_wr_a[10:0]] <= cdata_wr_a;
      wcnt_a <= wcnt_a + 1;
    end
    if (cwr_b) begin
      dst_b[caddr_wr_b[10:0]] <= cdata_wr_b;
      wcnt_b <= wcnt_b + 1;
    end
  end

  // Protocol monitor
  always @(negedge clk) begin
    if (crd_a && cwr_a) viol++;
    if (crd_a && csel_a != 3'b011) viol++;
    if (cwr_a && csel_a != 3'b101) viol++;
    if (!busy_a && csel_a != 3'b000) viol++;
    if (cwr_a && (caddr_wr_a[0] || caddr_wr_a > 12'd2047)) viol++;
    if (crd_b && cwr_b) viol++;
    if (crd_b && csel_b != 3'b011) viol++;
    if (cwr_b && csel_b != 3'b101) viol++;
    if (!busy_b && csel_b != 3'b000) viol++;
    if (cwr_b && (!caddr_wr_b[0] || caddr_wr_b > 12'd2047)) viol++;
    if (done_a) done_cnt_a++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic do_run(input bit b, output int n);
    int w0;
    @(negedge clk);
    w0 = b ? wcnt_b : wcnt_a;
    if (b) start_b = 1'b1;
    else   start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    chk("first_rd",
        b ? {19'd0, crd_b, caddr_rd_b} : {19'd0, crd_a, caddr_rd_a},
        {19'd0, 1'b1, 12'd0});
    n = 1;
    while (!(b ? done_b : done_a) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("run_cycles", n, 3073);
    chk("writes", (b ? wcnt_b : wcnt_a) - w0, 1024);
    @(negedge clk);
    chk("done_1cyc",
        b ? {30'd0, done_b, busy_b} : {30'd0, done_a, busy_a}, 0);
  endtask

  task automatic check_result(input bit b, input logic [19:0] emax,
                              input logic [9:0] eidx);
    int good;
    good = 0;
    for (int i = 0; i < 1024; i++) begin
      if (b) begin
        if (dst_b[2 * i + 1] === src[i]) good++;
      end else begin
        if (dst_a[2 * i] === src[i]) good++;
      end
    end
    chk("dst_words", good, 1024);
    chk("max_val", b ? max_val_b : max_val_a, emax);
    chk("max_idx", b ? max_idx_b : max_idx_a, eidx);
  endtask

  // Reference: largest word, first occurrence wins
  task automatic model_max(output logic [19:0] v, output logic [9:0] ix);
    v  = '0;
    ix = '0;
    for (int i = 0; i < 1024; i++) begin
      if (src[i] > v) begin
        v  = src[i];
        ix = 10'(i);
      end
    end
  endtask

  typedef struct {
    bit          ramp;
    logic [19:0] fill;
    int          h1;
    logic [19:0] v1;
    int          h2;
    logic [19:0] v2;
    logic [19:0] exp_max;
    logic [9:0]  exp_idx;
  } vec_t;

  initial begin
    vec_t vecs [6];
    int n;
    int m;
    int w0;
    int dc0;
    logic [19:0] mv;
    logic [9:0]  mi;

    vecs[0] = '{1'b1, 20'h0, -1, 20'h0, -1, 20'h0, 20'd1024, 10'd1023};
    vecs[1] = '{1'b0, 20'h0, 300, 20'hFFFFF, 700, 20'hFFFFF,
                20'hFFFFF, 10'd300};
    vecs[2] = '{1'b0, 20'h0, -1, 20'h0, -1, 20'h0, 20'h0, 10'd0};
    vecs[3] = '{1'b0, 20'h7, 1023, 20'h8, -1, 20'h0, 20'h8, 10'd1023};
    vecs[4] = '{1'b0, 20'h3, 0, 20'hFFFFF, 5, 20'hFFFFE,
                20'hFFFFF, 10'd0};
    vecs[5] = '{1'b0, 20'h80000, 512, 20'h80001, 513, 20'h80001,
                20'h80001, 10'd512};

    @(negedge clk);
    chk("rst_ctrl", {busy_a, done_a, crd_a, cwr_a, csel_a}, 0);
    chk("rst_addr", {caddr_rd_a, caddr_wr_a}, 0);
    chk("rst_wdata", cdata_wr_a, 0);
    chk("rst_max", {max_idx_a, max_val_a}, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 1024; i++)
        src[i] = vecs[v].ramp ? 20'(i + 1) : vecs[v].fill;
      if (vecs[v].h1 >= 0) src[vecs[v].h1] = vecs[v].v1;
      if (vecs[v].h2 >= 0) src[vecs[v].h2] = vecs[v].v2;
      do_run(1'b0, n);
      check_result(1'b0, vecs[v].exp_max, vecs[v].exp_idx);
    end

    for (int i = 0; i < 1024; i++) src[i] = 20'h00005;
    do_run(1'b1, n);
    check_result(1'b1, 20'h5, 10'd0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 1024; i++)
        src[i] = (r % 2 == 1) ? 20'($urandom_range(0, 15))
                              : 20'($urandom);
      model_max(mv, mi);
      do_run(1'b0, n);
      check_result(1'b0, mv, mi);
    end

    // Abort mid-run at idx 512 in WR
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    dc0 = done_cnt_a;
    n = 0;
    while (!(cwr_a && caddr_wr_a == 12'd1024) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_idx512", {31'd0, cwr_a && caddr_wr_a == 12'd1024}, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_state", {busy_a, cwr_a, csel_a, done_a}, 0);
    chk("abort_max", {max_idx_a, max_val_a}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt_a - dc0, 0);
    for (int i = 0; i < 1024; i++) src[i] = 20'($urandom);
    model_max(mv, mi);
    do_run(1'b0, n);
    check_result(1'b0, mv, mi);

    // Start held high across two runs
    for (int i = 0; i < 1024; i++) src[i] = 20'($urandom_range(0, 255));
    model_max(mv, mi);
    @(negedge clk);
    w0 = wcnt_a;
    start_a = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_a && n < 4000);
    chk("b2b_first", n, 3073);
    m = 0;
    do begin
      @(negedge clk);
      m++;
    end while (!done_a && m < 4000);
    start_a = 1'b0;
    chk("b2b_gap", m, 3074);
    chk("b2b_writes", wcnt_a - w0, 2048);
    check_result(1'b0, mv, mi);
    repeat (2) @(negedge clk);
    chk("b2b_idle", {31'd0, busy_a}, 0);

    chk("protocol_viol", viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
